// File: rtl/dmem_responder.sv
// Word-addressed data memory with fixed wait states for the pipeline M stage.
// Optional misaligned-access checking (MemErrM port) is enabled by defining DMEM_MISALIGN_CHK_EN.
module dmem_responder #(
  parameter int AW          = 6,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [31:0] ALUOutM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  output logic        MemReadyM,
  output logic        MemStallM
`ifdef DMEM_MISALIGN_CHK_EN
  ,
  output logic        MemErrM
`endif
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  // BUSY counts down from WAIT_CYCLES-2 so the access lands on the edge into DONE.
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 1) ? 4'(WAIT_CYCLES - 2) : 4'd0;

  state_t         state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic [31:0]    data_q, data_d;
  logic           write_q, write_d;
  logic           misal_q, misal_d;
  logic [31:0]    rdata_q, rdata_d;

  logic [31:0]    mem [2**AW];

  logic           req;
  logic           misal_in;
  logic           do_access;
  logic [AW-1:0]  acc_idx;
  logic [31:0]    acc_data;
  logic           acc_write;
  logic           acc_misal;
  logic           mem_we;
  logic           addr_unused;

  assign req = MemReadM | MemWriteM;

`ifdef DMEM_MISALIGN_CHK_EN
  assign misal_in = (ALUOutM[1:0] != 2'b00);
`else
  assign misal_in = 1'b0;
`endif

  // Upper address bits alias onto the array.
  assign addr_unused = ^{ALUOutM[31:AW+2], ALUOutM[1:0]};

  // NOTE: every output of this block gets a default first so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    data_d    = data_q;
    write_d   = write_q;
    misal_d   = misal_q;
    do_access = 1'b0;
    acc_idx   = addr_q;
    acc_data  = data_q;
    acc_write = write_q;
    acc_misal = misal_q;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          addr_d  = ALUOutM[AW+1:2];
          data_d  = WriteDataM;
          write_d = MemWriteM;
          misal_d = misal_in;
          if (WAIT_CYCLES == 1) begin
            do_access = 1'b1;
            acc_idx   = ALUOutM[AW+1:2];
            acc_data  = WriteDataM;
            acc_write = MemWriteM;
            acc_misal = misal_in;
            state_d   = DONE;
          end else begin
            cnt_d   = CNT_INIT;
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          do_access = 1'b1;
          state_d   = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A reset on the access edge must discard the store.
  assign mem_we = do_access & acc_write & ~acc_misal & ~reset;

  always_comb begin
    rdata_d = rdata_q;
    if (do_access && !acc_write) begin
      rdata_d = acc_misal ? 32'h0 : mem[acc_idx];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      data_q  <= 32'h0;
      write_q <= 1'b0;
      misal_q <= 1'b0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      write_q <= write_d;
      misal_q <= misal_d;
      rdata_q <= rdata_d;
    end
  end

  // NOTE: the memory array has no reset; its contents survive reset and stay uninitialised at power-up.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[acc_idx] <= acc_data;
    end
  end

  assign ReadDataM = rdata_q;
  assign MemReadyM = (state_q == DONE);
  assign MemStallM = req & ~MemReadyM;

`ifdef DMEM_MISALIGN_CHK_EN
  assign MemErrM = (state_q == DONE) & misal_q;
`endif

endmodule
